// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the round-robin APB arbiter.
// The APB_TIMEOUT_EN macro is consumed by apb_rr_arbiter, not by this package.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W_DEF = 32;
  localparam int APB_DATA_W_DEF = 32;

  // Width of a requester index; at least one bit even for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first requester above last_grant, wrapping.
module rr_arb_pick
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   idx_s;
  logic [IDX_W-1:0]   pos_s;
  logic               found_s;
  logic               hit_s;

  // Walk positions last_grant+1 .. last_grant+NUM_REQ; the first hit wins.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    pos_s   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos_s          = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      hit_s          = req[pos_s] & ~found_s;
      grant_s[pos_s] = grant_s[pos_s] | hit_s;
      idx_s          = hit_s ? pos_s : idx_s;
      found_s        = found_s | hit_s;
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;
  assign grant_any = found_s;

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB bus among NUM_REQ requesters.
// Define APB_TIMEOUT_EN to end ACCESS with rsp_err after TIMEOUT_CYC cycles without PREADY.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = APB_ADDR_W_DEF,
  parameter int DATA_W      = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY
);

  localparam int IDX_W = idx_width(NUM_REQ);

  apb_state_e         state_r;
  logic [IDX_W-1:0]   last_grant_r;
  logic [IDX_W-1:0]   winner_idx_r;
  logic [NUM_REQ-1:0] winner_oh_r;

  logic [NUM_REQ-1:0] pick_grant_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;
  logic               sel_write_s;
  logic               timeout_s;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .grant_idx  (pick_idx_s),
    .grant_any  (pick_any_s)
  );

  // Payload mux: grant is one-hot, so an AND-OR selects the winner's fields.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_write_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s  = sel_addr_s  | (req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{pick_grant_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{pick_grant_s[i]}});
      sel_write_s = sel_write_s | (req_write[i] & pick_grant_s[i]);
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_r;

  // Counts ACCESS cycles that ended without PREADY; cleared outside ACCESS.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      to_cnt_r <= '0;
    end else if (state_r == ACCESS && !PREADY) begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == ACCESS) && !PREADY && (to_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
  // Without the counter ACCESS never expires; TIMEOUT_CYC has no effect here.
  assign timeout_s = (TIMEOUT_CYC < 0);
`endif

  // Transfer sequencer: grant in IDLE, one SETUP cycle, ACCESS until PREADY or timeout.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_r      <= IDLE;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      winner_idx_r <= '0;
      winner_oh_r  <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            winner_idx_r <= pick_idx_s;
            winner_oh_r  <= pick_grant_s;
            req_ready    <= pick_grant_s;
            PWRITE       <= sel_write_s;
            PADDR        <= sel_addr_s;
            PWDATA       <= sel_wdata_s;
            PSEL         <= 1'b1;
            PENABLE      <= 1'b0;
            state_r      <= SETUP;
          end else begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
        end
        SETUP: begin
          PSEL    <= 1'b1;
          PENABLE <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid    <= winner_oh_r;
            rsp_rdata    <= PWRITE ? '0 : PRDATA;
            rsp_err      <= 1'b0;
            last_grant_r <= winner_idx_r;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            state_r      <= IDLE;
          end else if (timeout_s) begin
            rsp_valid    <= winner_oh_r;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b1;
            last_grant_r <= winner_idx_r;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            state_r      <= IDLE;
          end else begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b1;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: vector table for single transfers plus
// hand-written fairness, reset and timeout sequences.
module tb_apb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA;
  logic              PREADY;

  int checks = 0;
  int errors = 0;

  apb_rr_arbiter #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] er;
    int           got;
    int           bad;

    vecs[0] = '{id: 0, wr: 1'b1, addr: 32'h0000_0000, wdata: 32'd23,
                prdata: 32'hDEAD_BEEF, waits: 0, exp_rdata: 32'h0000_0000};
    vecs[1] = '{id: 1, wr: 1'b0, addr: 32'h0000_0004, wdata: 32'h1111_1111,
                prdata: 32'h2012_2023, waits: 3, exp_rdata: 32'h2012_2023};
    vecs[2] = '{id: 0, wr: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,
                prdata: 32'hA5A5_0F0F, waits: 1, exp_rdata: 32'hA5A5_0F0F};
    vecs[3] = '{id: 1, wr: 1'b1, addr: 32'h0000_0008, wdata: 32'hCAFE_F00D,
                prdata: 32'h5555_AAAA, waits: 2, exp_rdata: 32'h0000_0000};

    PRESET = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0;
    #1;
    check("reset_bus", {62'd0, PSEL, PENABLE}, 64'd0);
    check("reset_ready", req_ready, 64'd0);
    check("reset_rsp", {rsp_valid, rsp_err}, 64'd0);
    check("reset_paddr", PADDR, 64'd0);
    step(); step();
    PRESET = 1'b1;

    for (int v = 0; v < 4; v++) begin
      er = '0;
      er[vecs[v].id] = 1'b1;
      req_valid = er;
      req_write[vecs[v].id] = vecs[v].wr;
      req_addr[vecs[v].id*AW +: AW] = vecs[v].addr;
      req_wdata[vecs[v].id*DW +: DW] = vecs[v].wdata;
      step();
      check("accept", req_ready, er);
      check("setup_sel_en", {62'd0, PSEL, PENABLE}, 64'd2);
      check("setup_paddr", PADDR, vecs[v].addr);
      check("setup_pwrite", PWRITE, vecs[v].wr);
      check("setup_pwdata", PWDATA, vecs[v].wdata);
      // Requester moves on; bus payload must not follow.
      req_valid = '0;
      req_addr[vecs[v].id*AW +: AW] = vecs[v].addr + 32'h4;
      req_wdata[vecs[v].id*DW +: DW] = ~vecs[v].wdata;
      req_write[vecs[v].id] = ~vecs[v].wr;
      PRDATA = vecs[v].prdata;
      PREADY = (vecs[v].waits == 0);
      step();
      check("access_sel_en", {62'd0, PSEL, PENABLE}, 64'd3);
      check("access_no_rsp", rsp_valid, 64'd0);
      for (int k = 0; k < vecs[v].waits; k++) begin
        PREADY = 1'b0;
        step();
        check("wait_sel_en", {62'd0, PSEL, PENABLE}, 64'd3);
        check("wait_paddr", PADDR, vecs[v].addr);
        check("wait_pwdata", {31'd0, PWRITE, PWDATA}, {31'd0, vecs[v].wr, vecs[v].wdata});
        check("wait_no_rsp", rsp_valid, 64'd0);
      end
      PREADY = 1'b1;
      step();
      check("done_rsp_valid", rsp_valid, er);
      check("done_rdata", rsp_rdata, vecs[v].exp_rdata);
      check("done_err", rsp_err, 64'd0);
      check("done_bus_idle", {62'd0, PSEL, PENABLE}, 64'd0);
      PREADY = 1'b0;
      step();
      check("rsp_once", rsp_valid, 64'd0);
    end

    // Fairness: both requesters pending from reset, zero-wait slave.
    PRESET = 1'b0;
    step();
    PRESET = 1'b1;
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {32'h0000_0104, 32'h0000_0100};
    PREADY = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        step();
        if (req_ready != '0) got = 1;
      end
      check("fair_grant_seen", got, 64'd1);
      check("fair_grant", req_ready, (g % 2 == 0) ? 64'd1 : 64'd2);
    end
    req_valid = '0;
    repeat (4) step();

    // Asynchronous reset while in ACCESS.
    PREADY = 1'b0;
    req_valid = 2'b01;
    step();
    check("rst_accept", req_ready, 64'd1);
    req_valid = '0;
    step();
    check("rst_pre_access", {62'd0, PSEL, PENABLE}, 64'd3);
    #2;
    PRESET = 1'b0;
    #1;
    check("rst_async_drop", {62'd0, PSEL, PENABLE}, 64'd0);
    req_valid = 2'b11;
    PREADY = 1'b1;
    step();
    check("rst_no_rsp", rsp_valid, 64'd0);
    step();
    PRESET = 1'b1;
    step();
    check("rst_req0_first", req_ready, 64'd1);
    req_valid = '0;
    repeat (3) step();
    PREADY = 1'b0;
    step();

    // PREADY stuck low.
    req_valid = 2'b10;
    req_write[1] = 1'b0;
    req_addr[AW +: AW] = 32'h0000_0020;
    PRDATA = 32'h1234_5678;
    step();
    check("to_accept", req_ready, 64'd2);
    req_valid = '0;
    step();
    check("to_access", {62'd0, PSEL, PENABLE}, 64'd3);
`ifdef APB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      check("to_wait_no_rsp", rsp_valid, 64'd0);
    end
    step();
    check("to_rsp_valid", rsp_valid, 64'd2);
    check("to_rsp_err", rsp_err, 64'd1);
    check("to_rdata_zero", rsp_rdata, 64'd0);
    check("to_bus_idle", {62'd0, PSEL, PENABLE}, 64'd0);
`else
    bad = 0;
    repeat (100) begin
      step();
      if (rsp_valid != '0 || !(PSEL && PENABLE)) bad++;
    end
    check("no_timeout_hold", bad, 64'd0);
    PREADY = 1'b1;
    step();
    check("late_rsp_valid", rsp_valid, 64'd2);
    check("late_rsp_err", rsp_err, 64'd0);
    check("late_rdata", rsp_rdata, 64'h1234_5678);
`endif
    PREADY = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
